frame_deserializer: RTL and testbench
=====================================

// Module: frame_deserializer
// PURPOSE
//  Receive-side deframer. Consumes the byte stream produced by the channel serializer:
//  HEADER, NUM_CHANNELS data bytes, FOOTER. Checks frame structure, reassembles the
//  channels into one parallel word and emits a one-cycle frame_valid pulse.
//  Malformed or stalled frames are dropped and flagged; good and bad frames are counted.
// PARAMETERS
//  NUM_CHANNELS  4      data bytes per frame (>=1)
//  HEADER        8'hAA  frame start byte
//  FOOTER        8'hFF  frame end byte
//  TIMEOUT       16     idle cycles allowed inside a frame before abort; 0 disables
//  CNT_W         16     width of the frame and error counters
// PORTS
//  clk          in   1               system clock, rising edge
//  rst_n        in   1               asynchronous active-low reset
//  in_data      in   8               byte from upstream serializer (its dout)
//  in_valid     in   1               in_data qualifier (its dout_valid)
//  frame_data   out  8*NUM_CHANNELS  last good frame; channel k in bits [8k+7:8k]
//  frame_valid  out  1               1-cycle pulse: frame_data just updated
//  frame_err    out  1               1-cycle pulse: frame dropped
//  err_code     out  2               cause of last drop: 01 bad footer, 10 timeout; sticky
//  frame_count  out  CNT_W           good frames received, saturating
//  err_count    out  CNT_W           dropped frames, saturating
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low. All outputs, shadow buffer,
//   index and gap counter go to 0; state = HUNT. A partial frame in flight is discarded
//   with no pulse.
//  A byte is accepted only on a clk edge with in_valid=1. in_valid=0 bytes are ignored.
//  States:
//   HUNT: accepted byte == HEADER -> DATA, idx=0. Any other byte is discarded silently
//    (no error, no count).
//   DATA: accepted byte -> shadow[idx]. Position-based: HEADER/FOOTER values are
//    stored as data. idx==NUM_CHANNELS-1 -> FOOTER_CHK, otherwise idx++.
//   FOOTER_CHK: accepted byte == FOOTER -> frame_data<=shadow, frame_valid=1,
//    frame_count++, -> HUNT. Other byte -> frame_err=1, err_code=01, err_count++;
//    if that byte == HEADER -> DATA, idx=0 (immediate resync); else -> HUNT.
//  Timeout (TIMEOUT>0, states DATA/FOOTER_CHK only):
//   - gap counter clears on every accepted byte and on entry to DATA;
//     it increments each cycle with in_valid=0.
//   - When the TIMEOUT-th consecutive idle cycle is reached: frame_err=1, err_code=10,
//     err_count++, -> HUNT.
//   - An accepted byte in that same cycle wins; no timeout fires.
//   - The gap counter is inactive in HUNT.
//  Latency: all outputs are registered. frame_valid/frame_err assert on the edge that
//   accepts the deciding byte (visible the following cycle) and are held for exactly 1 cycle.
//   Back-to-back frames with no idle gap are supported (footer, then header next cycle).
//  frame_data changes only on a good frame and holds otherwise.
//  err_code holds until the next error.
//  Counters saturate at all-ones and never wrap.
//  frame_valid and frame_err are never asserted together.
// TESTING
//  1 Good frame: AA 11 22 33 44 FF back-to-back -> one frame_valid pulse,
//    frame_data=32'h44332211, frame_count=1, err_count=0.
//  2 Junk + bubbles: 00 55 FF, then AA 11 (2 idle) 22 33 44 FF -> one good frame
//    32'h44332211; no frame_err.
//  3 Bad footer + resync: AA 01 02 03 04 AA 05 06 07 08 FF -> frame_err, err_code=01,
//    err_count=1, then frame_valid with frame_data=32'h08070605.
//  4 Timeout (TIMEOUT=8): AA 01 02, then 8 idle cycles -> frame_err, err_code=10,
//    frame_data unchanged; a following good frame is accepted.
//  5 Payload aliasing: AA AA FF AA FF FF -> frame_valid, frame_data=32'hFFAAFFAA.
//  6 Reset mid-frame: AA 01, pulse rst_n low, then 02 03 04 FF -> no pulses,
//    counters 0; next full frame is good. Also force saturation with CNT_W=2.

Source files
------------

// File: rtl/frame_deserializer.sv
// Receive-side deframer: hunts for HEADER, collects NUM_CHANNELS payload bytes,
// checks FOOTER, and publishes the reassembled word or flags the dropped frame.
module frame_deserializer #(
  parameter int         NUM_CHANNELS = 4,
  parameter logic [7:0] HEADER       = 8'hAA,
  parameter logic [7:0] FOOTER       = 8'hFF,
  parameter int         TIMEOUT      = 16,
  parameter int         CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic [8*NUM_CHANNELS-1:0] frame_data,
  output logic                      frame_valid,
  output logic                      frame_err,
  output logic [1:0]                err_code,
  output logic [CNT_W-1:0]          frame_count,
  output logic [CNT_W-1:0]          err_count
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    HUNT       = 2'd0,
    DATA       = 2'd1,
    FOOTER_CHK = 2'd2
  } state_t;

  state_t                           state, state_nxt;
  logic [IDX_W-1:0]                 idx, idx_nxt;
  logic [GAP_W-1:0]                 gap, gap_nxt;
  logic [NUM_CHANNELS-1:0][7:0]     shadow;
  logic                             store, good, bad_footer, timed_out;
  logic                             timeout_hit;

  // The gap counter only needs to reach TIMEOUT-1; the next idle cycle is the abort.
  assign timeout_hit = (TIMEOUT != 0) && (gap == GAP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      idx   <= '0;
      gap   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      gap   <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    gap_nxt    = gap;
    store      = 1'b0;
    good       = 1'b0;
    bad_footer = 1'b0;
    timed_out  = 1'b0;
    case (state)
      HUNT: begin
        gap_nxt = '0;
        if (in_valid && in_data == HEADER) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (in_valid) begin
          store   = 1'b1;
          gap_nxt = '0;
          if (idx == LAST_IDX) state_nxt = FOOTER_CHK;
          else                 idx_nxt   = idx + 1'b1;
        end else if (timeout_hit) begin
          timed_out = 1'b1;
          state_nxt = HUNT;
          gap_nxt   = '0;
        end else if (TIMEOUT != 0) begin
          gap_nxt = gap + 1'b1;
        end
      end
      FOOTER_CHK: begin
        if (in_valid) begin
          gap_nxt = '0;
          if (in_data == FOOTER) begin
            good      = 1'b1;
            state_nxt = HUNT;
          end else begin
            // A wrong footer that is itself a header starts the next frame at once.
            bad_footer = 1'b1;
            if (in_data == HEADER) begin
              state_nxt = DATA;
              idx_nxt   = '0;
            end else begin
              state_nxt = HUNT;
            end
          end
        end else if (timeout_hit) begin
          timed_out = 1'b1;
          state_nxt = HUNT;
          gap_nxt   = '0;
        end else if (TIMEOUT != 0) begin
          gap_nxt = gap + 1'b1;
        end
      end
      default: begin
        state_nxt = HUNT;
        idx_nxt   = '0;
        gap_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (store) shadow[idx] <= in_data;
      frame_valid <= good;
      frame_err   <= bad_footer | timed_out;
      if (good) frame_data <= shadow;
      if (bad_footer)     err_code <= 2'b01;
      else if (timed_out) err_code <= 2'b10;
      // Both counters stick at all-ones rather than wrapping.
      if (good && frame_count != {CNT_W{1'b1}})
        frame_count <= frame_count + 1'b1;
      if ((bad_footer || timed_out) && err_count != {CNT_W{1'b1}})
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_deserializer.sv
// Bench for frame_deserializer: directed vector table, hand corner sequences and
// randomized framed traffic checked against a queue-based reference model.
module tb_frame_deserializer;

  localparam int         NC   = 4;
  localparam logic [7:0] HDR  = 8'hAA;
  localparam logic [7:0] FTR  = 8'hFF;
  localparam int         TOUT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic [31:0]   frame_data;
  logic          frame_valid, frame_err;
  logic [1:0]    err_code;
  logic [15:0]   frame_count, err_count;
  logic [31:0]   sat_frame_data;
  logic          sat_frame_valid, sat_frame_err;
  logic [1:0]    sat_err_code;
  logic [1:0]    sat_frame_count, sat_err_count;

  frame_deserializer #(.NUM_CHANNELS(NC), .HEADER(HDR), .FOOTER(FTR),
                       .TIMEOUT(TOUT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
    .err_code(err_code), .frame_count(frame_count), .err_count(err_count)
  );

  // Narrow-counter copy on the same stream to exercise saturation.
  frame_deserializer #(.NUM_CHANNELS(NC), .HEADER(HDR), .FOOTER(FTR),
                       .TIMEOUT(TOUT), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .frame_data(sat_frame_data), .frame_valid(sat_frame_valid),
    .frame_err(sat_frame_err), .err_code(sat_err_code),
    .frame_count(sat_frame_count), .err_count(sat_err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame in progress is a byte queue plus an idle-run length.
  bit          in_frame;
  logic [7:0]  payload[$];
  int          idle_run;
  int          good_frames, dropped_frames;
  logic        exp_valid, exp_err;
  logic [31:0] exp_data;
  logic [1:0]  exp_code;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        fv;
    logic        fe;
    logic [31:0] data;
    logic [1:0]  code;
  } vec_t;
  vec_t vecs[$];

  function automatic int sat_at(input int n, input int lim);
    return (n > lim) ? lim : n;
  endfunction

  task automatic model_reset();
    in_frame = 0;
    payload.delete();
    idle_run = 0;
    good_frames = 0;
    dropped_frames = 0;
    exp_valid = 0;
    exp_err = 0;
    exp_data = '0;
    exp_code = 2'b00;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d);
    exp_valid = 0;
    exp_err = 0;
    if (!in_frame) begin
      if (v && d == HDR) begin
        in_frame = 1;
        payload.delete();
        idle_run = 0;
      end
    end else if (v) begin
      idle_run = 0;
      if (payload.size() < NC) begin
        payload.push_back(d);
      end else if (d == FTR) begin
        exp_valid = 1;
        for (int k = 0; k < NC; k++) exp_data[8*k +: 8] = payload[k];
        good_frames++;
        in_frame = 0;
      end else begin
        exp_err = 1;
        exp_code = 2'b01;
        dropped_frames++;
        if (d == HDR) payload.delete();
        else in_frame = 0;
      end
    end else begin
      idle_run++;
      if (idle_run == TOUT) begin
        exp_err = 1;
        exp_code = 2'b10;
        dropped_frames++;
        in_frame = 0;
      end
    end
  endtask

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check_field("frame_valid", 32'(frame_valid), 32'(exp_valid));
    check_field("frame_err", 32'(frame_err), 32'(exp_err));
    check_field("frame_data", frame_data, exp_data);
    check_field("err_code", 32'(err_code), 32'(exp_code));
    check_field("frame_count", 32'(frame_count), 32'(sat_at(good_frames, 65535)));
    check_field("err_count", 32'(err_count), 32'(sat_at(dropped_frames, 65535)));
    check_field("sat_frame_count", 32'(sat_frame_count), 32'(sat_at(good_frames, 3)));
    check_field("sat_err_count", 32'(sat_err_count), 32'(sat_at(dropped_frames, 3)));
    check_field("sat_frame_valid", 32'(sat_frame_valid), 32'(exp_valid));
    check_field("sat_frame_err", 32'(sat_frame_err), 32'(exp_err));
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic add_vec(input logic v, input logic [7:0] d, input logic fv, input logic fe,
                         input logic [31:0] data, input logic [1:0] code);
    vec_t e;
    e.v = v; e.d = d; e.fv = fv; e.fe = fe; e.data = data; e.code = code;
    vecs.push_back(e);
  endtask

  task automatic send_byte_rand_gap(input logic [7:0] b);
    int r;
    r = int'($urandom_range(0, 19));
    if (r >= 18) idle((r == 18) ? TOUT - 1 : int'($urandom_range(TOUT, TOUT + 2)));
    else if (r >= 14) idle(int'($urandom_range(1, 2)));
    applyStimulus(1'b1, b);
  endtask

  function automatic logic [7:0] rand_payload();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return HDR;
    if (r == 1) return FTR;
    return 8'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    // Good frame, junk with bubbles, payload aliasing, bad footer with resync.
    add_vec(1, 8'hAA, 0, 0, 32'h0, 2'b00);
    add_vec(1, 8'h11, 0, 0, 32'h0, 2'b00);
    add_vec(1, 8'h22, 0, 0, 32'h0, 2'b00);
    add_vec(1, 8'h33, 0, 0, 32'h0, 2'b00);
    add_vec(1, 8'h44, 0, 0, 32'h0, 2'b00);
    add_vec(1, 8'hFF, 1, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'h00, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'h55, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'hFF, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'hAA, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'h11, 0, 0, 32'h44332211, 2'b00);
    add_vec(0, 8'h00, 0, 0, 32'h44332211, 2'b00);
    add_vec(0, 8'h00, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'h22, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'h33, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'h44, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'hFF, 1, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'hAA, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'hAA, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'hFF, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'hAA, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'hFF, 0, 0, 32'h44332211, 2'b00);
    add_vec(1, 8'hFF, 1, 0, 32'hFFAAFFAA, 2'b00);
    add_vec(1, 8'hAA, 0, 0, 32'hFFAAFFAA, 2'b00);
    add_vec(1, 8'h01, 0, 0, 32'hFFAAFFAA, 2'b00);
    add_vec(1, 8'h02, 0, 0, 32'hFFAAFFAA, 2'b00);
    add_vec(1, 8'h03, 0, 0, 32'hFFAAFFAA, 2'b00);
    add_vec(1, 8'h04, 0, 0, 32'hFFAAFFAA, 2'b00);
    add_vec(1, 8'hAA, 0, 1, 32'hFFAAFFAA, 2'b01);
    add_vec(1, 8'h05, 0, 0, 32'hFFAAFFAA, 2'b01);
    add_vec(1, 8'h06, 0, 0, 32'hFFAAFFAA, 2'b01);
    add_vec(1, 8'h07, 0, 0, 32'hFFAAFFAA, 2'b01);
    add_vec(1, 8'h08, 0, 0, 32'hFFAAFFAA, 2'b01);
    add_vec(1, 8'hFF, 1, 0, 32'h08070605, 2'b01);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].d);
      check_field($sformatf("vec%0d_valid", i), 32'(frame_valid), 32'(vecs[i].fv));
      check_field($sformatf("vec%0d_err", i), 32'(frame_err), 32'(vecs[i].fe));
      check_field($sformatf("vec%0d_data", i), frame_data, vecs[i].data);
      check_field($sformatf("vec%0d_code", i), 32'(err_code), 32'(vecs[i].code));
    end
    check_field("table_frame_count", 32'(frame_count), 32'd4);
    check_field("table_err_count", 32'(err_count), 32'd1);
    check_field("table_sat_frame_count", 32'(sat_frame_count), 32'd3);

    // Timeout in DATA after TOUT idle cycles; data untouched, next frame accepted.
    applyStimulus(1, 8'hAA); applyStimulus(1, 8'h01); applyStimulus(1, 8'h02);
    idle(TOUT - 1);
    check_field("pre_timeout_err", 32'(frame_err), 32'd0);
    idle(1);
    check_field("timeout_err", 32'(frame_err), 32'd1);
    check_field("timeout_code", 32'(err_code), 32'd2);
    check_field("timeout_data_hold", frame_data, 32'h08070605);
    applyStimulus(1, 8'hAA); applyStimulus(1, 8'h10); applyStimulus(1, 8'h20);
    applyStimulus(1, 8'h30); applyStimulus(1, 8'h40); applyStimulus(1, 8'hFF);
    check_field("post_timeout_good", frame_data, 32'h40302010);

    // A byte arriving on the would-be timeout cycle wins.
    applyStimulus(1, 8'hAA); applyStimulus(1, 8'h01);
    idle(TOUT - 1);
    applyStimulus(1, 8'h02);
    check_field("byte_wins_err", 32'(frame_err), 32'd0);
    applyStimulus(1, 8'h03); applyStimulus(1, 8'h04);
    idle(TOUT - 1);
    applyStimulus(1, 8'hFF);
    check_field("byte_wins_good", frame_data, 32'h04030201);

    // Timeout while waiting for the footer.
    applyStimulus(1, 8'hAA); applyStimulus(1, 8'h05); applyStimulus(1, 8'h06);
    applyStimulus(1, 8'h07); applyStimulus(1, 8'h08);
    idle(TOUT);
    check_field("footer_timeout_err", 32'(frame_err), 32'd1);
    check_field("footer_timeout_code", 32'(err_code), 32'd2);

    // Reset mid-frame: remainder of the frame must be ignored.
    applyStimulus(1, 8'hAA); applyStimulus(1, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 8'h02); applyStimulus(1, 8'h03);
    applyStimulus(1, 8'h04); applyStimulus(1, 8'hFF);
    check_field("reset_no_valid", 32'(frame_valid), 32'd0);
    check_field("reset_frame_count", 32'(frame_count), 32'd0);
    check_field("reset_err_count", 32'(err_count), 32'd0);
    applyStimulus(1, 8'hAA); applyStimulus(1, 8'hA1); applyStimulus(1, 8'hB2);
    applyStimulus(1, 8'hC3); applyStimulus(1, 8'hD4); applyStimulus(1, 8'hFF);
    check_field("reset_next_good", frame_data, 32'hD4C3B2A1);

    // Randomized framed traffic with occasional corruption, junk and long gaps.
    for (int f = 0; f < 250; f++) begin
      if ($urandom_range(0, 9) == 0) send_byte_rand_gap(rand_payload());
      send_byte_rand_gap(HDR);
      for (int k = 0; k < NC; k++) send_byte_rand_gap(rand_payload());
      send_byte_rand_gap(($urandom_range(0, 6) == 0) ? rand_payload() : FTR);
    end
    idle(TOUT + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
